// File: rtl/ir_pkg.sv
// Shared definitions for the pulse-distance IR link (receiver and transmitter).
// Holds the receiver state encoding, protocol unit multiples and the
// tolerance windows, expressed as functions of the ticks-per-unit setting.
package ir_pkg;

    typedef enum logic [2:0] {
        IR_IDLE,
        IR_START_MARK,
        IR_START_SPACE,
        IR_BIT_MARK,
        IR_BIT_SPACE,
        IR_STOP_MARK
    } ir_rx_state_t;

    // Nominal protocol durations in units
    localparam int unsigned START_MARK_U  = 16;
    localparam int unsigned START_SPACE_U = 8;
    localparam int unsigned ONE_SPACE_U   = 3;
    localparam int unsigned TIMEOUT_U     = 24;

    // Start mark accepted in [12U, 20U]
    function automatic int unsigned start_mark_min(input int unsigned t);
        return 12 * t;
    endfunction

    function automatic int unsigned start_mark_max(input int unsigned t);
        return 20 * t;
    endfunction

    // Start space accepted in [6U, 10U]
    function automatic int unsigned start_space_min(input int unsigned t);
        return 6 * t;
    endfunction

    function automatic int unsigned start_space_max(input int unsigned t);
        return 10 * t;
    endfunction

    // Bit and stop marks accepted in [U/2, 3U/2]
    function automatic int unsigned bit_mark_min(input int unsigned t);
        return t / 2;
    endfunction

    function automatic int unsigned bit_mark_max(input int unsigned t);
        return (3 * t) / 2;
    endfunction

    // '0' space in [U/2, 2U); '1' space in [2U, 4U]
    function automatic int unsigned zero_space_min(input int unsigned t);
        return t / 2;
    endfunction

    function automatic int unsigned one_space_min(input int unsigned t);
        return 2 * t;
    endfunction

    function automatic int unsigned one_space_max(input int unsigned t);
        return 4 * t;
    endfunction

    // Any pulse this long in a non-idle state aborts the frame
    function automatic int unsigned timeout_ticks(input int unsigned t);
        return TIMEOUT_U * t;
    endfunction

    function automatic logic in_range(input int unsigned d,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/ir_line_conditioner.sv
// Input conditioning for the IR receiver: two-flop synchronizer, optional
// glitch filter (enabled by defining IR_RX_GLITCH_FILTER_EN) and polarity
// correction so that o_line is 1 during a mark. Edge strobes compare the
// conditioned line against its one-cycle delayed copy.
module ir_line_conditioner #(
    parameter int unsigned INVERT_IN     = 1,
    parameter int unsigned GLITCH_CYCLES = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_signal,
    output logic o_line,
    output logic o_rise,
    output logic o_fall
);

    // Raw pin level while the link is idle (space)
    localparam logic IDLE_RAW = (INVERT_IN != 0);

    if (GLITCH_CYCLES < 1) begin : g_glitch_cfg_check
        $error("ir_line_conditioner: GLITCH_CYCLES must be at least 1");
    end

    logic r_sync1;
    logic r_sync2;
    logic r_line_d;
    logic w_level;

    // Two-flop synchronizer for the asynchronous pin, parked at the idle level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= IDLE_RAW;
            r_sync2 <= IDLE_RAW;
        end else begin
            r_sync1 <= i_signal;
            r_sync2 <= r_sync1;
        end
    end

`ifdef IR_RX_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);

    logic          r_filt;
    logic [GW-1:0] r_filt_cnt;

    // Accept a new level only after it has persisted for GLITCH_CYCLES cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filt     <= IDLE_RAW;
            r_filt_cnt <= '0;
        end else if (r_sync2 == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == GW'(GLITCH_CYCLES - 1)) begin
            r_filt     <= r_sync2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign o_line = w_level ^ IDLE_RAW;

    // Delayed line copy for edge detection; reset to space
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_line_d <= 1'b0;
        end else begin
            r_line_d <= o_line;
        end
    end

    assign o_rise = o_line & ~r_line_d;
    assign o_fall = ~o_line & r_line_d;

endmodule

// File: rtl/ir_receiver.sv
// Pulse-distance IR frame decoder. Measures mark/space durations on the
// conditioned line, walks the frame with a state machine and emits each
// MESSAGE_LENGTH-bit letter as a one-cycle valid pulse. Malformed or stalled
// frames produce a one-cycle error pulse. Optional input glitch filter is
// enabled by defining IR_RX_GLITCH_FILTER_EN.
module ir_receiver
    import ir_pkg::*;
#(
    parameter int unsigned MESSAGE_LENGTH = 5,
    parameter int unsigned TICKS_PER_UNIT = 56250,
    parameter int unsigned INVERT_IN      = 1,
    parameter int unsigned GLITCH_CYCLES  = 1000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      signal_in,
    output logic [MESSAGE_LENGTH-1:0] data_out,
    output logic                      data_valid_out,
    output logic                      error_out,
    output logic                      busy_out
);

    localparam int unsigned TO_TICKS = timeout_ticks(TICKS_PER_UNIT);
    localparam int          DW       = $clog2(TO_TICKS + 1);
    localparam int          IW       = (MESSAGE_LENGTH > 1) ? $clog2(MESSAGE_LENGTH) : 1;
    localparam logic [DW-1:0] DUR_SAT = DW'(TO_TICKS);
    localparam logic [IW-1:0] IDX_LAST = IW'(MESSAGE_LENGTH - 1);

    localparam int unsigned SM_MIN   = start_mark_min(TICKS_PER_UNIT);
    localparam int unsigned SM_MAX   = start_mark_max(TICKS_PER_UNIT);
    localparam int unsigned SS_MIN   = start_space_min(TICKS_PER_UNIT);
    localparam int unsigned SS_MAX   = start_space_max(TICKS_PER_UNIT);
    localparam int unsigned MK_MIN   = bit_mark_min(TICKS_PER_UNIT);
    localparam int unsigned MK_MAX   = bit_mark_max(TICKS_PER_UNIT);
    localparam int unsigned ZERO_MIN = zero_space_min(TICKS_PER_UNIT);
    localparam int unsigned ONE_MIN  = one_space_min(TICKS_PER_UNIT);
    localparam int unsigned ONE_MAX  = one_space_max(TICKS_PER_UNIT);

    logic w_line;
    logic w_rise;
    logic w_fall;

    ir_line_conditioner #(
        .INVERT_IN     (INVERT_IN),
        .GLITCH_CYCLES (GLITCH_CYCLES)
    ) u_cond (
        .i_clk    (clk_in),
        .i_rst    (rst_in),
        .i_signal (signal_in),
        .o_line   (w_line),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    ir_rx_state_t              r_state;
    logic [DW-1:0]             r_dur;
    logic [IW-1:0]             r_idx;
    logic [MESSAGE_LENGTH-1:0] r_shift;
    logic [MESSAGE_LENGTH-1:0] r_data;
    logic                      r_valid;
    logic                      r_err;
    logic                      r_busy;

    logic [31:0] w_dur;
    logic        w_timeout;
    logic        w_sm_ok;
    logic        w_ss_ok;
    logic        w_mark_ok;
    logic        w_zero;
    logic        w_one;
    logic        w_term;
    logic        w_ok;

    // Duration of the current level: cleared on each edge, saturates at the timeout
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_dur <= '0;
        end else if (w_rise || w_fall) begin
            r_dur <= '0;
        end else if (r_dur != DUR_SAT) begin
            r_dur <= r_dur + 1'b1;
        end
    end

    assign w_dur     = 32'(r_dur);
    assign w_timeout = (r_dur == DUR_SAT);
    assign w_sm_ok   = in_range(w_dur, SM_MIN, SM_MAX);
    assign w_ss_ok   = in_range(w_dur, SS_MIN, SS_MAX);
    assign w_mark_ok = in_range(w_dur, MK_MIN, MK_MAX);
    assign w_zero    = (w_dur >= ZERO_MIN) && (w_dur < ONE_MIN);
    assign w_one     = in_range(w_dur, ONE_MIN, ONE_MAX);

    // Select the edge that terminates the pulse measured in this state and its window check
    always_comb begin
        w_term = 1'b0;
        w_ok   = 1'b0;
        case (r_state)
            IR_START_MARK: begin
                w_term = w_fall;
                w_ok   = w_sm_ok;
            end
            IR_START_SPACE: begin
                w_term = w_rise;
                w_ok   = w_ss_ok;
            end
            IR_BIT_MARK, IR_STOP_MARK: begin
                w_term = w_fall;
                w_ok   = w_mark_ok;
            end
            IR_BIT_SPACE: begin
                w_term = w_rise;
                w_ok   = w_zero | w_one;
            end
            default: begin
                w_term = 1'b0;
                w_ok   = 1'b0;
            end
        endcase
    end

    // Frame state machine with registered valid, error and busy outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IR_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if ((r_state != IR_IDLE) && (w_timeout || (w_term && !w_ok))) begin
                // Abort; the offending edge is consumed here, so IDLE waits for a fresh rise
                r_state <= IR_IDLE;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    IR_IDLE: begin
                        if (w_rise) begin
                            r_state <= IR_START_MARK;
                            r_busy  <= 1'b1;
                        end
                    end
                    IR_START_MARK: begin
                        if (w_term) begin
                            r_state <= IR_START_SPACE;
                        end
                    end
                    IR_START_SPACE: begin
                        if (w_term) begin
                            r_idx   <= '0;
                            r_shift <= '0;
                            r_state <= IR_BIT_MARK;
                        end
                    end
                    IR_BIT_MARK: begin
                        if (w_term) begin
                            r_state <= IR_BIT_SPACE;
                        end
                    end
                    IR_BIT_SPACE: begin
                        if (w_term) begin
                            r_shift[r_idx] <= w_one;
                            if (r_idx == IDX_LAST) begin
                                r_state <= IR_STOP_MARK;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= IR_BIT_MARK;
                            end
                        end
                    end
                    IR_STOP_MARK: begin
                        if (w_term) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= IR_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IR_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out       = r_data;
    assign data_valid_out = r_valid;
    assign error_out      = r_err;
    assign busy_out       = r_busy;

    // Line level itself is only consumed through its edges
    logic w_line_unused;
    assign w_line_unused = w_line;

endmodule

// File: tb/tb_ir_receiver.sv
// Self-checking bench for ir_receiver (U=100 cycles, GLITCH_CYCLES=5, active-high input).
// Frames are built from a vector table plus hand-written corner sequences;
// expected letters go into a scoreboard queue and are popped on each valid pulse.
module tb_ir_receiver;

    localparam int U  = 100;
    localparam int ML = 5;
`ifdef IR_RX_GLITCH_FILTER_EN
    localparam int LAT     = 5;
    localparam bit FILT    = 1'b1;
    localparam int MIN_GAP = 5;
`else
    localparam int LAT     = 0;
    localparam bit FILT    = 1'b0;
    localparam int MIN_GAP = 1;
`endif

    logic          clk_in    = 1'b0;
    logic          rst_in    = 1'b1;
    logic          signal_in = 1'b0;
    logic [ML-1:0] data_out;
    logic          data_valid_out;
    logic          error_out;
    logic          busy_out;

    ir_receiver #(
        .MESSAGE_LENGTH (ML),
        .TICKS_PER_UNIT (U),
        .INVERT_IN      (0),
        .GLITCH_CYCLES  (5)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .signal_in      (signal_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .error_out      (error_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [ML-1:0] bits_sent;  // bit i is transmitted i-th
        int            pct_start;  // stretch of start mark/space in percent
        int            pct_bit;    // stretch of bit/stop pulses in percent
        int            gap;        // idle space after the stop mark
        logic [ML-1:0] exp_data;
    } vec_t;

    int            total    = 0;
    int            bad      = 0;
    int            err_seen = 0;
    logic          prev_v   = 1'b0;
    logic          prev_e   = 1'b0;
    logic [ML-1:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge and checked against the scoreboard
    task automatic tick();
        logic [ML-1:0] e;
        @(posedge clk_in);
        @(negedge clk_in);
        if (data_valid_out || error_out) begin
            check("valid_error_exclusive", int'(data_valid_out && error_out), 0);
            check("pulse_one_cycle", int'((data_valid_out && prev_v) || (error_out && prev_e)), 0);
        end
        if (data_valid_out) begin
            check("scoreboard_nonempty", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("letter", int'(data_out), int'(e));
            end
        end
        if (error_out) err_seen++;
        prev_v = data_valid_out;
        prev_e = error_out;
    endtask

    task automatic hold(input logic v, input int n);
        signal_in = v;
        repeat (n) tick();
    endtask

    function automatic int scale(input int units, input int pct);
        return (units * U * (100 + pct)) / 100;
    endfunction

    // Full frame; with spike set, a 3-cycle mark is injected 20 cycles into every bit space
    task automatic send_frame(input logic [ML-1:0] d, input int ps, input int pb,
                              input int gap, input bit spike);
        int sp;
        hold(1'b1, scale(16, ps));
        hold(1'b0, scale(8, ps));
        for (int i = 0; i < ML; i++) begin
            hold(1'b1, scale(1, pb));
            sp = scale(d[i] ? 3 : 1, pb);
            if (spike) begin
                hold(1'b0, 20);
                hold(1'b1, 3);
                hold(1'b0, sp - 23);
            end else begin
                hold(1'b0, sp);
            end
        end
        hold(1'b1, scale(1, pb));
        hold(1'b0, gap);
    endtask

    initial begin
        vec_t vt[5];
        int   e0;
        int   got;

        // Bit order is LSB first: 5'b10110 goes out as 0,1,1,0,1.
        // Start fields use +/-20% so they stay inside the [12U,20U]/[6U,10U] windows;
        // bit fields use the full +/-30%.
        vt[0] = '{5'b10110,   0,   0, 300,     5'h16};
        vt[1] = '{5'b10110,  20,  30, 300,     5'h16};
        vt[2] = '{5'b00001, -20, -30, 300,     5'h01};
        vt[3] = '{5'b00000,   0,   0, MIN_GAP, 5'h00};
        vt[4] = '{5'b11011,   0,   0, 300,     5'h1B};

        rst_in    = 1'b1;
        signal_in = 1'b0;
        repeat (3) tick();
        check("reset_data", int'(data_out), 0);
        check("reset_valid", int'(data_valid_out), 0);
        check("reset_error", int'(error_out), 0);
        check("reset_busy", int'(busy_out), 0);
        rst_in = 1'b0;
        hold(1'b0, 50);

        // Table-driven frames: nominal, stretched, shrunk, back-to-back pair
        for (int i = 0; i < 5; i++) begin
            e0 = err_seen;
            exp_q.push_back(vt[i].exp_data);
            send_frame(vt[i].bits_sent, vt[i].pct_start, vt[i].pct_bit, vt[i].gap, 1'b0);
            check("vec_no_error", err_seen - e0, 0);
        end
        check("table_drained", exp_q.size(), 0);
        check("idle_not_busy", int'(busy_out), 0);
        check("table_last_letter", int'(data_out), 'h1B);

        // Start mark of 8U is rejected on its falling edge
        e0 = err_seen;
        hold(1'b1, 8 * U);
        hold(1'b0, 10);
        check("short_start_error", err_seen - e0, 1);
        check("short_start_busy", int'(busy_out), 0);
        hold(1'b0, 300);
        exp_q.push_back(5'h1F);
        send_frame(5'h1F, 0, 0, 300, 1'b0);
        check("after_error_drained", exp_q.size(), 0);
        check("after_error_letter", int'(data_out), 'h1F);

        // Mark held 30U after the start space: error exactly when the count reaches 24U
        e0 = err_seen;
        hold(1'b1, 16 * U);
        hold(1'b0, 8 * U);
        signal_in = 1'b1;
        got = -1;
        for (int k = 1; k <= 3000; k++) begin
            tick();
            if (error_out) begin
                got = k;
                break;
            end
        end
        check("timeout_cycle", got, 2404 + LAT);
        check("timeout_error_count", err_seen - e0, 1);
        check("timeout_data_kept", int'(data_out), 'h1F);
        check("timeout_busy", int'(busy_out), 0);
        if (got > 0) hold(1'b1, 30 * U - got);
        hold(1'b0, 300);
        check("timeout_fall_ignored", err_seen - e0, 1);

        // Reset pulse in the middle of bit 3's space of frame 5'h0A
        e0 = err_seen;
        hold(1'b1, 16 * U);
        hold(1'b0, 8 * U);
        hold(1'b1, U); hold(1'b0, U);
        hold(1'b1, U); hold(1'b0, 3 * U);
        hold(1'b1, U); hold(1'b0, U);
        hold(1'b1, U); hold(1'b0, 150);
        rst_in = 1'b1;
        tick();
        check("midreset_data", int'(data_out), 0);
        check("midreset_valid", int'(data_valid_out), 0);
        check("midreset_error", int'(error_out), 0);
        check("midreset_busy", int'(busy_out), 0);
        rst_in = 1'b0;
        hold(1'b0, 30 * U);
        check("midreset_quiet", err_seen - e0, 0);
        exp_q.push_back(5'h0A);
        send_frame(5'h0A, 0, 0, 300, 1'b0);
        check("midreset_drained", exp_q.size(), 0);
        check("midreset_letter", int'(data_out), 'h0A);

        // Short spikes in the spaces: absorbed by the filter, fatal without it
        e0 = err_seen;
        if (FILT) exp_q.push_back(5'h05);
        send_frame(5'h05, 0, 0, 300, 1'b1);
        check("spike_error", int'(err_seen - e0 > 0), FILT ? 0 : 1);
        check("spike_letter", int'(data_out), FILT ? 'h05 : 'h0A);
        check("spike_drained", exp_q.size(), 0);
        check("final_busy", int'(busy_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
